// File: rtl/uriscv_dmem_wb_bridge.sv
//-----------------------------------------------------------------------------
// uriscv_dmem_wb_bridge
//
// Bridges the uriscv core native data-memory port (rd/wr/accept/ack with
// request tags) to a pipelined Wishbone master. Up to MAX_OUTSTANDING
// transfers may be in flight. Response tags are returned in request order
// from a small tag FIFO.
//
// Optional feature: define UPRISCV_BRIDGE_TIMEOUT_EN to enable a response
// timeout. If no wb_ack_i arrives for TIMEOUT_CYCLES cycles while transfers
// are outstanding, the head entry is retired with mem_ack_o and mem_error_o
// pulsed together and read data 0. Without the macro mem_error_o is tied 0.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   mem_addr_i          core data address (word aligned on the bus)
//   mem_data_wr_i       core write data
//   mem_rd_i            read request
//   mem_wr_i            byte write strobes, nonzero means write (write wins)
//   mem_req_tag_i       request tag
//   mem_accept_o        request accepted this cycle (combinational)
//   mem_ack_o           one-cycle response pulse
//   mem_data_rd_o       response read data (0 for writes and errors)
//   mem_error_o         response is an error (timeout)
//   mem_resp_tag_o      tag of the returned request
//   wb_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o   Wishbone master outputs
//   wb_dat_i/ack_i/stall_i                  Wishbone slave responses
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module uriscv_dmem_wb_bridge #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int TAG_W           = 11,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      mem_data_wr_i,
    input  logic             mem_rd_i,
    input  logic [3:0]       mem_wr_i,
    input  logic [TAG_W-1:0] mem_req_tag_i,
    output logic             mem_accept_o,
    output logic             mem_ack_o,
    output logic [31:0]      mem_data_rd_o,
    output logic             mem_error_o,
    output logic [TAG_W-1:0] mem_resp_tag_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [3:0]       wb_sel_o,
    output logic [31:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_stall_i
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Per-entry tag and write flag; the flag forces read data to 0 for writes.
    logic [TAG_W-1:0] tag_mem [MAX_OUTSTANDING];
    logic             we_mem  [MAX_OUTSTANDING];

    logic req;
    logic is_write;
    logic count_nz;
    logic accept;
    logic ack_take;
    logic timeout_hit;
    logic pop;
    logic stb_kill;

    // Byte lanes are carried by wb_sel_o, so the low address bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr_i[1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (MAX_OUTSTANDING == 1) ? '0 : p + 1'b1;
    endfunction

    assign req      = mem_rd_i | (|mem_wr_i);
    assign is_write = |mem_wr_i;
    assign count_nz = (count != '0);

    // A stalled strobe still owns the Wishbone output registers, so no new
    // request may be captured until it is taken.
    assign accept       = req & (count < CNT_MAX) & ~(wb_stb_o & wb_stall_i);
    assign mem_accept_o = accept;

    // Acks with nothing outstanding are spurious and ignored.
    assign ack_take = wb_ack_i & count_nz;
    assign pop      = ack_take | timeout_hit;
    assign wb_cyc_o = count_nz;

    // The strobe always carries the newest entry. It is the head only when a
    // single entry is outstanding, so a timeout then retires an unissued strobe.
    assign stb_kill = timeout_hit & (count == CNT_ONE);

    // NOTE: the FIFO storage has no reset; an entry is always written before
    // it is read, and the pointers and count are what reset clears.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            tag_mem[wr_ptr] <= mem_req_tag_i;
            we_mem[wr_ptr]  <= is_write;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            wb_stb_o       <= 1'b0;
            wb_we_o        <= 1'b0;
            wb_sel_o       <= 4'h0;
            wb_adr_o       <= '0;
            wb_dat_o       <= '0;
            mem_ack_o      <= 1'b0;
            mem_data_rd_o  <= '0;
            mem_resp_tag_o <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            if (accept) begin
                wr_ptr   <= ptr_inc(wr_ptr);
                wb_adr_o <= {mem_addr_i[31:2], 2'b00};
                wb_dat_o <= mem_data_wr_i;
                wb_we_o  <= is_write;
                wb_sel_o <= is_write ? mem_wr_i : 4'hF;
            end

            wb_stb_o <= accept | (wb_stb_o & wb_stall_i & ~stb_kill);

            mem_ack_o <= pop;
            if (pop) begin
                rd_ptr         <= ptr_inc(rd_ptr);
                mem_resp_tag_o <= tag_mem[rd_ptr];
                mem_data_rd_o  <= (timeout_hit | we_mem[rd_ptr]) ? 32'h0 : wb_dat_i;
            end
        end
    end

`ifdef UPRISCV_BRIDGE_TIMEOUT_EN
    logic [31:0] timer;

    assign timeout_hit = count_nz & ~wb_ack_i & (timer == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer       <= '0;
            mem_error_o <= 1'b0;
        end else begin
            mem_error_o <= timeout_hit;
            // Restarting on a timeout gives the next entry a full window.
            if (!count_nz || wb_ack_i || timeout_hit) begin
                timer <= '0;
            end else begin
                timer <= timer + 32'd1;
            end
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign mem_error_o = 1'b0;
`endif

endmodule
